// File: rtl/wb_pwm_n.sv
// wb_pwm_n: multi-channel PWM behind an 8-bit zero-wait-state Wishbone register file,
// with shadowed period/duty registers and a period-wrap interrupt.

// One PWM channel: active duty register plus registered compare output.
module wb_pwm_lane #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             load,
   input  logic [CNT_W-1:0] cnt,
   input  logic [CNT_W-1:0] duty_sh,
   output logic             pwm
);
   logic [CNT_W-1:0] duty_act;

   always_ff @(posedge clk) begin
      if (rst) begin
         duty_act <= '0;
         pwm      <= 1'b0;
      end else begin
         if (load) duty_act <= duty_sh;
         pwm <= en && (cnt < duty_act);
      end
   end
endmodule

module wb_pwm_n #(
   parameter int N_CH      = 6,
   parameter int CNT_W     = 8,
   parameter int CNT_PRESC = 24
) (
   input  logic            wb_clk_i,
   input  logic            wb_rst_i,
   input  logic [4:0]      wb_adr_i,
   input  logic [7:0]      wb_dat_i,
   output logic [7:0]      wb_dat_o,
   input  logic            wb_we_i,
   input  logic            wb_stb_i,
   output logic            wb_ack_o,
   output logic [N_CH-1:0] pwm_o,
   output logic [N_CH-1:0] pwm_e_o,
   output logic            irq_req_o,
   input  logic            irq_ack_i
);
   localparam int            PW        = (CNT_PRESC > 1) ? $clog2(CNT_PRESC) : 1;
   localparam logic [PW-1:0] PRESC_MAX = PW'(CNT_PRESC - 1);

   logic                        en, irq_en, upd, irq_f;
   logic [7:0]                  ena;
   logic [PW-1:0]               presc;
   logic [CNT_W-1:0]            cnt, per_sh, per_act;
   logic [N_CH-1:0][CNT_W-1:0]  duty_sh;
   logic                        wr, wr_ctrl, tick, wrap, load;

   // Registers are CNT_W wide but addressed as bytes; bits at/above CNT_W vanish.
   function automatic logic [CNT_W-1:0] put_byte(logic [CNT_W-1:0] old, logic [7:0] b, logic hi);
      logic [15:0] t;
      t = 16'(old);
      if (hi) t[15:8] = b;
      else    t[7:0]  = b;
      return t[CNT_W-1:0];
   endfunction

   function automatic logic [7:0] get_byte(logic [CNT_W-1:0] v, logic hi);
      logic [15:0] t;
      t = 16'(v);
      return hi ? t[15:8] : t[7:0];
   endfunction

   assign wr        = wb_stb_i && wb_we_i;
   assign wr_ctrl   = wr && (wb_adr_i == 5'd0);
   assign tick      = en && (presc == PRESC_MAX);
   assign wrap      = tick && (cnt == per_act);
   // While disabled the active set tracks the shadow set continuously.
   assign load      = !en || (wrap && upd);
   assign wb_ack_o  = wb_stb_i;
   assign irq_req_o = irq_f && irq_en;
   assign pwm_e_o   = ena[N_CH-1:0];

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         en      <= 1'b0;
         irq_en  <= 1'b0;
         upd     <= 1'b0;
         irq_f   <= 1'b0;
         ena     <= '0;
         per_sh  <= '1;
         per_act <= '1;
         presc   <= '0;
         cnt     <= '0;
      end else begin
         if (wr_ctrl) begin
            en     <= wb_dat_i[0];
            irq_en <= wb_dat_i[1];
         end
         // A UPD write landing on the consuming wrap stays pending for the next one.
         if (!en)                         upd <= 1'b0;
         else if (wr_ctrl && wb_dat_i[2]) upd <= 1'b1;
         else if (wrap)                   upd <= 1'b0;

         if (wrap)                                         irq_f <= 1'b1;
         else if (irq_ack_i || (wr_ctrl && wb_dat_i[3]))   irq_f <= 1'b0;

         if (wr && wb_adr_i == 5'd1) ena    <= wb_dat_i;
         if (wr && wb_adr_i == 5'd2) per_sh <= put_byte(per_sh, wb_dat_i, 1'b0);
         if (wr && wb_adr_i == 5'd3) per_sh <= put_byte(per_sh, wb_dat_i, 1'b1);
         if (load) per_act <= per_sh;

         if (!en || tick) presc <= '0;
         else             presc <= presc + 1'b1;

         if (!en || wrap) cnt <= '0;
         else if (tick)   cnt <= cnt + 1'b1;
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         duty_sh <= '0;
      end else begin
         for (int k = 0; k < N_CH; k++) begin
            if (wr && wb_adr_i == 5'(8 + 2*k)) duty_sh[k] <= put_byte(duty_sh[k], wb_dat_i, 1'b0);
            if (wr && wb_adr_i == 5'(9 + 2*k)) duty_sh[k] <= put_byte(duty_sh[k], wb_dat_i, 1'b1);
         end
      end
   end

   always_comb begin
      wb_dat_o = 8'h00;
      case (wb_adr_i)
         5'd0:    wb_dat_o = {4'b0000, irq_f, upd, irq_en, en};
         5'd1:    wb_dat_o = ena;
         5'd2:    wb_dat_o = get_byte(per_sh, 1'b0);
         5'd3:    wb_dat_o = get_byte(per_sh, 1'b1);
         default: begin
            for (int k = 0; k < N_CH; k++) begin
               if (wb_adr_i == 5'(8 + 2*k)) wb_dat_o = get_byte(duty_sh[k], 1'b0);
               if (wb_adr_i == 5'(9 + 2*k)) wb_dat_o = get_byte(duty_sh[k], 1'b1);
            end
         end
      endcase
   end

   for (genvar k = 0; k < N_CH; k++) begin : g_lane
      wb_pwm_lane #(.CNT_W(CNT_W)) u_lane (
         .clk     (wb_clk_i),
         .rst     (wb_rst_i),
         .en      (en),
         .load    (load),
         .cnt     (cnt),
         .duty_sh (duty_sh[k]),
         .pwm     (pwm_o[k])
      );
   end
endmodule

// File: tb/tb_wb_pwm_n.sv
// Directed bench for wb_pwm_n (N_CH=2, CNT_W=8, CNT_PRESC=2) with hand-computed expectations.
module tb_wb_pwm_n;
   logic       clk_sys = 1'b0;
   logic       rst = 1'b0;
   logic [4:0] adr = '0;
   logic [7:0] dat_w = '0;
   logic [7:0] dat_r;
   logic       we = 1'b0, stb = 1'b0, ack, irq_req, irq_ack = 1'b0;
   logic [1:0] pwm, pwm_e;

   int n_vec = 0;
   int n_err = 0;

   wb_pwm_n #(.N_CH(2), .CNT_W(8), .CNT_PRESC(2)) dut (
      .wb_clk_i (clk_sys),
      .wb_rst_i (rst),
      .wb_adr_i (adr),
      .wb_dat_i (dat_w),
      .wb_dat_o (dat_r),
      .wb_we_i  (we),
      .wb_stb_i (stb),
      .wb_ack_o (ack),
      .pwm_o    (pwm),
      .pwm_e_o  (pwm_e),
      .irq_req_o(irq_req),
      .irq_ack_i(irq_ack)
   );

   always #5 clk_sys = ~clk_sys;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic wb_wr(input logic [4:0] a, input logic [7:0] d);
      @(negedge clk_sys);
      adr = a; dat_w = d; we = 1'b1; stb = 1'b1;
      @(posedge clk_sys); #1;
      we = 1'b0; stb = 1'b0;
   endtask

   task automatic wb_rd(input logic [4:0] a, output logic [7:0] d);
      @(negedge clk_sys);
      adr = a; we = 1'b0; stb = 1'b1;
      #1;
      d = dat_r;
      chk("ack", 32'(ack), 32'd1);
      stb = 1'b0;
   endtask

   task automatic rd_chk(input string tag, input logic [4:0] a, input logic [7:0] exp);
      logic [7:0] d;
      wb_rd(a, d);
      chk(tag, 32'(d), 32'(exp));
   endtask

   // Measure one pwm_o[0] period starting at a rising edge; also counts pwm_o[1] highs.
   task automatic measure(output int hi, output int lo, output int ch1_hi);
      int guard;
      hi = 0; lo = 0; ch1_hi = 0; guard = 0;
      while (pwm[0] !== 1'b0 && guard < 200) begin @(negedge clk_sys); guard++; end
      while (pwm[0] !== 1'b1 && guard < 200) begin @(negedge clk_sys); guard++; end
      while (pwm[0] === 1'b1 && guard < 200) begin
         hi++; if (pwm[1]) ch1_hi++; @(negedge clk_sys); guard++;
      end
      while (pwm[0] === 1'b0 && guard < 200) begin
         lo++; if (pwm[1]) ch1_hi++; @(negedge clk_sys); guard++;
      end
      if (guard >= 200) chk("measure_timeout", 32'(guard), 32'd0);
   endtask

   initial begin
      int hi, lo, c1, n;
      logic [7:0] d;

      // Reset state
      rst = 1'b1;
      repeat (2) @(posedge clk_sys);
      #1 rst = 1'b0;
      rd_chk("rst_ctrl", 5'd0, 8'h00);
      rd_chk("rst_ena",  5'd1, 8'h00);
      rd_chk("rst_perl", 5'd2, 8'hFF);
      rd_chk("rst_perh", 5'd3, 8'h00);
      rd_chk("rst_duty0", 5'd8, 8'h00);
      chk("rst_pwm", 32'(pwm), 32'd0);
      chk("rst_irq", 32'(irq_req), 32'd0);

      // Basic waveform: period 9, duty 3, prescale 2
      wb_wr(5'd2, 8'd9);
      wb_wr(5'd8, 8'd3);
      wb_wr(5'd10, 8'd0);
      rd_chk("perl_rb", 5'd2, 8'd9);
      rd_chk("rsvd_rd", 5'd4, 8'h00);
      wb_wr(5'd0, 8'h01);
      measure(hi, lo, c1);
      chk("wave_hi", 32'(hi), 32'd6);
      chk("wave_lo", 32'(lo), 32'd14);
      chk("ch1_zero", 32'(c1), 32'd0);

      // Shadow write without UPD leaves the waveform alone
      wb_wr(5'd8, 8'd7);
      measure(hi, lo, c1);
      chk("noupd_hi", 32'(hi), 32'd6);
      chk("noupd_lo", 32'(lo), 32'd14);
      wb_wr(5'd0, 8'h05);
      wb_rd(5'd0, d);
      chk("upd_pend", 32'(d[2]), 32'd1);
      measure(hi, lo, c1);
      chk("upd_hi", 32'(hi), 32'd14);
      chk("upd_lo", 32'(lo), 32'd6);
      wb_rd(5'd0, d);
      chk("upd_clr", 32'(d[2]), 32'd0);

      // Interrupt: first wrap lands 20 clocks after enable
      wb_wr(5'd0, 8'h08);
      chk("irq_off", 32'(irq_req), 32'd0);
      rd_chk("if_clr", 5'd0, 8'h00);
      wb_wr(5'd0, 8'h03);
      n = 0;
      while (irq_req !== 1'b1 && n < 60) begin @(posedge clk_sys); #1; n++; end
      chk("irq_lat", 32'(n), 32'd20);
      @(negedge clk_sys); irq_ack = 1'b1;
      @(posedge clk_sys); #1 irq_ack = 1'b0;
      chk("irq_ack_clr", 32'(irq_req), 32'd0);
      repeat (18) @(posedge clk_sys);
      @(negedge clk_sys); irq_ack = 1'b1;
      @(posedge clk_sys); #1 irq_ack = 1'b0;
      chk("irq_set_wins", 32'(irq_req), 32'd1);

      // Duty above period: constant high; pin-enable mask independent of EN
      wb_wr(5'd0, 8'h00);
      chk("pe_rst", 32'(pwm_e), 32'd0);
      wb_wr(5'd10, 8'h10);
      wb_wr(5'd0, 8'h01);
      @(posedge clk_sys); #1;
      n = 0;
      for (int i = 0; i < 40; i++) begin @(negedge clk_sys); if (!pwm[1]) n++; end
      chk("ch1_const1", 32'(n), 32'd0);
      wb_wr(5'd1, 8'h03);
      chk("pe_mask", 32'(pwm_e), 32'd3);
      wb_wr(5'd0, 8'h00);
      @(posedge clk_sys); #1;
      chk("dis_pwm", 32'(pwm), 32'd0);
      chk("pe_dis", 32'(pwm_e), 32'd3);

      // Reset mid-run with UPD pending and IF set; reset beats a coincident write
      wb_wr(5'd0, 8'h03);
      repeat (25) @(posedge clk_sys);
      wb_wr(5'd0, 8'h07);
      wb_rd(5'd0, d);
      chk("pre_rst_ctrl", 32'(d[3:2]), 32'd3);
      @(negedge clk_sys);
      rst = 1'b1; adr = 5'd1; dat_w = 8'hAA; we = 1'b1; stb = 1'b1;
      @(posedge clk_sys); #1;
      rst = 1'b0; we = 1'b0; stb = 1'b0;
      chk("r2_pwm", 32'(pwm), 32'd0);
      chk("r2_pe", 32'(pwm_e), 32'd0);
      chk("r2_irq", 32'(irq_req), 32'd0);
      rd_chk("r2_ctrl", 5'd0, 8'h00);
      rd_chk("r2_ena",  5'd1, 8'h00);
      rd_chk("r2_perl", 5'd2, 8'hFF);
      rd_chk("r2_duty1", 5'd10, 8'h00);
      wb_wr(5'd3, 8'hFF);
      rd_chk("perh_trunc", 5'd3, 8'h00);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/wb_pwm_n.md
WB_PWM_N -- requirements
Module: wb_pwm_n

Interface
REQ-001 Parameter N_CH, default 6, number of PWM channels (1..8).
REQ-002 Parameter CNT_W, default 8, counter/period/duty width in bits (8..16).
REQ-003 Parameter CNT_PRESC, default 24, clock cycles per counter tick (>=1).
REQ-004 wb_clk_i  in  1  single clock; all state on its rising edge.
REQ-005 wb_rst_i  in  1  reset, synchronous, active-high.
REQ-006 wb_adr_i  in  5  register address.
REQ-007 wb_dat_i  in  8  write data.
REQ-008 wb_dat_o  out  8  read data.
REQ-009 wb_we_i  in  1  write enable.
REQ-010 wb_stb_i  in  1  strobe.
REQ-011 wb_ack_o  out  1  acknowledge.
REQ-012 pwm_o  out  N_CH  PWM outputs.
REQ-013 pwm_e_o  out  N_CH  per-channel pin-enable mask.
REQ-014 irq_req_o  out  1  period-wrap interrupt request.
REQ-015 irq_ack_i  in  1  interrupt acknowledge from IRQ controller.

Function
REQ-016 Bus: wb_ack_o SHALL equal wb_stb_i combinationally (zero wait states); write takes effect at the edge where stb&we; read data combinational from address.
REQ-017 Map: 0 CTRL, 1 ENA mask, 2 PERIOD_L, 3 PERIOD_H, 4-7 reserved, 8+2k DUTY_L[k], 9+2k DUTY_H[k], k<N_CH; unmapped/reserved reads 0, writes ignored.
REQ-018 CTRL bits: b0 EN, b1 IRQ_EN (R/W); b2 UPD (write 1 sets, reads pending, write 0 no effect); b3 IF (reads irq flag, write 1 clears); b7..b4 read 0.
REQ-019 PERIOD/DUTY writes go to shadow registers; bits at/above CNT_W SHALL be discarded and read 0; reads return shadow values.
REQ-020 Prescaler counts 0..CNT_PRESC-1; tick pulses one cycle when it equals CNT_PRESC-1, then wraps to 0.
REQ-021 Counter cnt (CNT_W bits) increments on tick; on tick with cnt==period_active it wraps to 0 (wrap event).
REQ-022 pwm_o[k] SHALL be registered: 1 iff EN=1 and cnt<duty_active[k]; duty 0 gives constant 0; duty>period gives constant 1.
REQ-023 pwm_e_o SHALL equal ENA mask bits [N_CH-1:0] regardless of EN.
REQ-024 EN=0: prescaler and cnt held at 0, pwm_o 0, active registers copied from shadow every cycle, UPD cleared.
REQ-025 EN=1: active registers load from shadow only on a wrap event with UPD=1; UPD clears in the same cycle; a CPU write of UPD=1 coinciding with that wrap leaves UPD=1 and is applied at the next wrap.
REQ-026 Wrap event SHALL set IF; irq_req_o = IF & IRQ_EN.
REQ-027 IF cleared by irq_ack_i=1 or CTRL write with b3=1; set and clear in same cycle: set wins.
REQ-028 Clearing EN mid-period SHALL take effect next cycle with no wrap event generated.

Reset
REQ-029 On wb_rst_i=1 at a clock edge: CTRL=0, ENA=0, shadow and active PERIOD = 2^CNT_W-1, all DUTY=0, prescaler=0, cnt=0, pwm_o=0, pwm_e_o=0, irq_req_o=0.
REQ-030 Reset SHALL take priority over any simultaneous bus write, tick or irq_ack_i.

Verification (N_CH=2, CNT_W=8, CNT_PRESC=2)
REQ-031 Reset then read addresses 0,1,2,3,8 -> 0x00,0x00,0xFF,0x00,0x00; pwm_o=0, irq_req_o=0.
REQ-032 PERIOD=9, DUTY[0]=3, DUTY[1]=0, EN=1 -> pwm_o[0] high 6 clocks, low 14, period 20 clocks; pwm_o[1] constant 0.
REQ-033 Running, write DUTY[0]=7 without UPD -> waveform unchanged; then write UPD=1 -> high time 14 clocks starting at next wrap, CTRL b2 reads 0 after it.
REQ-034 IRQ_EN=1, EN=1 -> irq_req_o rises on first wrap; irq_ack_i pulse clears it; irq_ack_i coinciding with a wrap leaves it set.
REQ-035 DUTY[1]=0x10 with PERIOD=9 -> pwm_o[1] constant 1 while EN=1; write ENA=0x03 -> pwm_e_o=2'b11.
REQ-036 wb_rst_i asserted mid-period with pending UPD and IF set -> all REQ-029 values on next cycle; address 3 write 0xFF with CNT_W=8 reads back 0x00.
